// File: rtl/moore_pkg.sv
// ---------------------------------------------------------------------------
// moore_pkg : shared helpers and defaults for the serial sequence detector
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package moore_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int         c_PAT_W_DEF   = 8;
    localparam int         c_LEN_W_DEF   = clog2(c_PAT_W_DEF + 1);
    localparam logic [7:0] c_RST_PAT_DEF = 8'h0B;
    localparam int         c_RST_LEN_DEF = 4;

    typedef logic [c_LEN_W_DEF-1:0] depth_t;
    typedef logic [c_LEN_W_DEF-1:0] len_t;

endpackage

`default_nettype wire

// File: rtl/seq_prefix_match.sv
// ---------------------------------------------------------------------------
// seq_prefix_match : next match depth via longest pattern-prefix / history-suffix
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_prefix_match #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic [PAT_W-1:0] hist,
    input  logic             b,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] depth,
    input  logic             ovl,
    output logic [LEN_W-1:0] next_depth
);

    localparam logic [PAT_W:0] c_ONES = {(PAT_W+1){1'b1}};

    logic [PAT_W:0]   w_seq;
    logic [PAT_W:0]   w_pat_x;
    logic [PAT_W:0]   w_mask;
    logic [PAT_W:0]   w_pref;
    logic [LEN_W-1:0] w_next;
    int               w_lim;

    assign w_seq   = {hist, b};
    assign w_pat_x = {1'b0, pat};

    // Shifting the pattern right by len-k leaves its first k bits at the LSBs,
    // lined up against the k most recent bits (newest at bit 0).
    always_comb begin
        w_next = '0;
        w_mask = '0;
        w_pref = '0;
        w_lim  = 0;
        if ((depth == len) && !ovl) begin
            w_pref = w_pat_x >> (int'(len) - 1);
            w_next = (w_pref[0] == b) ? LEN_W'(1) : '0;
        end else begin
            w_lim = int'(depth) + 1;
            if (w_lim > int'(len)) w_lim = int'(len);
            for (int k = 1; k <= PAT_W; k++) begin
                if (k <= w_lim) begin
                    w_mask = ~(c_ONES << k);
                    w_pref = w_pat_x >> (int'(len) - k);
                    if ((w_seq & w_mask) == (w_pref & w_mask)) w_next = LEN_W'(k);
                end
            end
        end
    end

    assign next_depth = w_next;

endmodule

`default_nettype wire

// File: rtl/moore_seq_detector.sv
// ---------------------------------------------------------------------------
// moore_seq_detector : programmable Moore serial sequence detector with
//                      saturating match counter
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module moore_seq_detector
    import moore_pkg::*;
#(
    parameter int             PAT_W   = c_PAT_W_DEF,
    parameter int             CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(c_RST_PAT_DEF),
    parameter int             RST_LEN = c_RST_LEN_DEF,
    localparam int            LEN_W   = clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [LEN_W-1:0] depth,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] c_RST_LEN = LEN_W'(RST_LEN);

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_depth;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [LEN_W-1:0] w_next_depth;
    logic [LEN_W-1:0] w_len_clamped;
    logic             w_accept;
    logic             w_hit;

    assign w_accept = en && !cfg_load;
    assign w_hit    = w_accept && (w_next_depth == r_len);

    always_comb begin
        w_len_clamped = cfg_len;
        if (cfg_len == '0)            w_len_clamped = LEN_W'(1);
        else if (cfg_len > c_MAX_LEN) w_len_clamped = c_MAX_LEN;
    end

    seq_prefix_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .hist       (r_hist),
        .b          (x),
        .pat        (r_pat),
        .len        (r_len),
        .depth      (r_depth),
        .ovl        (r_ovl),
        .next_depth (w_next_depth)
    );

    // Depth is the FSM state; y is registered alongside so it reflects state only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat   <= RST_PAT;
            r_len   <= c_RST_LEN;
            r_ovl   <= 1'b1;
            r_hist  <= '0;
            r_depth <= '0;
            r_y     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (cfg_load) begin
                r_pat   <= cfg_pat;
                r_len   <= w_len_clamped;
                r_ovl   <= cfg_overlap;
                r_hist  <= '0;
                r_depth <= '0;
                r_y     <= 1'b0;
            end else if (en) begin
                r_hist  <= {r_hist[PAT_W-2:0], x};
                r_depth <= w_next_depth;
                r_y     <= (w_next_depth == r_len);
            end

            if (clr_cnt)                  r_cnt <= '0;
            else if (w_hit && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign y         = r_y;
    assign depth     = r_depth;
    assign match_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_moore_seq_detector : directed self-checking bench for moore_seq_detector
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_moore_seq_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pat = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       clr_cnt = 1'b0;

    logic       y, y_s;
    logic [3:0] depth, depth_s;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    moore_seq_detector dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_cnt(clr_cnt), .y(y), .depth(depth), .match_cnt(match_cnt)
    );

    moore_seq_detector #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
        .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .clr_cnt(clr_cnt), .y(y_s), .depth(depth_s), .match_cnt(match_cnt_s)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en = e;
        x  = b;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pat     = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_load    = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    initial begin
        logic [6:0] s1;
        int         d1 [7];
        int         y1 [7];
        int         d2 [7];
        int         y2 [7];
        logic [3:0] s4;
        int         y4 [4];
        logic [7:0] s8;

        s1 = 7'b1011011;
        d1 = '{1, 2, 3, 4, 2, 3, 4};
        y1 = '{0, 0, 0, 1, 0, 0, 1};
        d2 = '{1, 2, 3, 4, 0, 1, 1};
        y2 = '{0, 0, 0, 1, 0, 0, 0};
        s4 = 4'b1101;
        y4 = '{1, 1, 0, 1};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_depth", int'(depth), 0);
        check("rst_y", int'(y), 0);
        check("rst_cnt", int'(match_cnt), 0);
        rst = 1'b0;

        // 1: default pattern 1011 with overlap
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[6-i]);
            check($sformatf("t1_depth%0d", i), int'(depth), d1[i]);
            check($sformatf("t1_y%0d", i), int'(y), y1[i]);
        end
        check("t1_cnt", int'(match_cnt), 2);

        // 2: same pattern, non-overlapping
        load(8'h0B, 4'd4, 1'b0);
        check("t2_load_depth", int'(depth), 0);
        check("t2_load_cnt", int'(match_cnt), 2);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s1[6-i]);
            check($sformatf("t2_depth%0d", i), int'(depth), d2[i]);
            check($sformatf("t2_y%0d", i), int'(y), y2[i]);
        end
        check("t2_cnt", int'(match_cnt), 3);

        // 3: enable gaps hold state
        load(8'h0B, 4'd4, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("t3_gap_depth%0d", i), int'(depth), 3);
            check($sformatf("t3_gap_y%0d", i), int'(y), 0);
        end
        step(1'b1, 1'b1);
        check("t3_match_depth", int'(depth), 4);
        check("t3_match_y", int'(y), 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0);
            check($sformatf("t3_hold_y%0d", i), int'(y), 1);
            check($sformatf("t3_hold_depth%0d", i), int'(depth), 4);
        end
        check("t3_cnt", int'(match_cnt), 4);

        // 4: single-bit pattern, then len=0 clamped to 1 with junk upper bits
        load(8'h01, 4'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s4[3-i]);
            check($sformatf("t4_y%0d", i), int'(y), y4[i]);
        end
        check("t4_cnt", int'(match_cnt), 7);
        load(8'h03, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s4[3-i]);
            check($sformatf("t4_len0_y%0d", i), int'(y), y4[i]);
        end
        check("t4_len0_cnt", int'(match_cnt), 10);

        // len above PAT_W clamps to the full 8-bit pattern
        load(8'hA5, 4'd15, 1'b1);
        s8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, s8[7-i]);
            if (i == 6) check("t4_clamp_y_early", int'(y), 0);
        end
        check("t4_clamp_depth", int'(depth), 8);
        check("t4_clamp_y", int'(y), 1);

        // 5: saturation on the 2-bit counter, clear priority
        clr_cnt = 1'b1;
        step(1'b0, 1'b0);
        clr_cnt = 1'b0;
        check("t5_clr_cnt", int'(match_cnt), 0);
        check("t5_clr_cnt_s", int'(match_cnt_s), 0);
        load(8'h01, 4'd1, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        check("t5_cnt_s_sat", int'(match_cnt_s), 3);
        check("t5_cnt_wide", int'(match_cnt), 5);
        clr_cnt = 1'b1;
        step(1'b1, 1'b1);
        clr_cnt = 1'b0;
        check("t5_clr_hit_cnt", int'(match_cnt), 0);
        check("t5_clr_hit_cnt_s", int'(match_cnt_s), 0);
        check("t5_clr_hit_y", int'(y), 1);

        // 6: async reset mid-pattern; pattern 10010 non-overlap
        load(8'h12, 4'd5, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        check("t6_match_y", int'(y), 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("t6_pre_depth", int'(depth), 3);
        check("t6_pre_cnt", int'(match_cnt), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_depth", int'(depth), 0);
        check("t6_rst_y", int'(y), 0);
        check("t6_rst_cnt", int'(match_cnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, s1[6-i]);
        check("t6_rstpat_depth", int'(depth), 4);
        check("t6_rstpat_y", int'(y), 1);

        // cfg_load wins over an accepted bit
        cfg_pat     = 8'h0B;
        cfg_len     = 4'd4;
        cfg_overlap = 1'b1;
        cfg_load    = 1'b1;
        step(1'b1, 1'b1);
        cfg_load = 1'b0;
        check("t6_load_en_depth", int'(depth), 0);
        check("t6_load_en_y", int'(y), 0);
        check("t6_load_en_cnt", int'(match_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
